riscv_core_mul_iter: RTL
========================

// Module: riscv_core_mul_iter
// PURPOSE
// - Multi-cycle iterative RV64M multiplier: MUL/MULH/MULHSU/MULHU/MULW.
// - Successor to the single-cycle Booth/compressor multiplier; trades latency for area.
// - Retires RADIX_BITS multiplier bits per cycle; valid/ready on both sides; flushable.
// - Sits in EX beside the ALU; the pipeline stalls on o_mul_in_ready/o_mul_out_valid.
// PARAMETERS
// - XLEN        64  operand/result width (32 or 64)
// - RADIX_BITS  4   multiplier bits per iteration (1,2,4,8); must divide 32
// PORTS
// - i_clk            in   1     clock, rising edge
// - i_rst            in   1     synchronous reset, active-high
// - i_mul_in_valid   in   1     request valid
// - o_mul_in_ready   out  1     request accepted when valid&ready
// - i_mul_srcA       in   XLEN  rs1
// - i_mul_srcB       in   XLEN  rs2
// - i_mul_control    in   2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
// - i_mul_isword     in   1     MULW; overrides i_mul_control
// - i_mul_flush      in   1     kill in-flight op
// - o_mul_out_valid  out  1     result valid
// - i_mul_out_ready  in   1     consumer accepts result
// - o_mul_result     out  XLEN  result
// - o_mul_busy       out  1     state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; o_mul_in_ready=1, o_mul_out_valid=0, o_mul_result=0, o_mul_busy=0.
// - FSM IDLE->CALC->FIX->DONE->IDLE; o_mul_in_ready=1 only in IDLE; one op in flight.
// - IDLE: on valid&ready, latch |A|, |B| and neg_res per op signedness; go to CALC.
//   MUL/MULH: A,B signed; MULHSU: A signed, B unsigned; MULHU: both unsigned.
//   MULW: W=32, operands = srcA[31:0], srcB[31:0] (sign irrelevant for low half).
// - CALC: acc += (mplr[RADIX_BITS-1:0] * mcnd) << shift; mplr >>= RADIX_BITS;
//   NSTEP = W/RADIX_BITS iterations (W = XLEN, or 32 for MULW); step counter 0..NSTEP-1.
// - FIX (1 cycle): negate 2*XLEN product if neg_res; select:
//   MUL -> prod[XLEN-1:0]; MULH* -> prod[2XLEN-1:XLEN]; MULW -> sext(prod[31:0]).
// - DONE: o_mul_out_valid=1, result held stable until i_mul_out_ready; then IDLE.
// - Latency: accept at edge k -> o_mul_out_valid high after edge k+NSTEP+1 (one FIX cycle).
// - Magnitudes use XLEN-bit unsigned; |-2^(XLEN-1)| = 2^(XLEN-1) is exact, no overflow.
// - i_mul_flush: any state -> IDLE next edge, o_mul_out_valid=0, no result emitted;
//   flush wins over a simultaneous in_valid (request not accepted).
// - DONE with out_ready and flush same cycle: treated as flushed (no handshake).
// - i_rst mid-operation: same as flush plus output register cleared to 0.
// - Inputs are sampled only at acceptance; changes during CALC are ignored.
// CONFIGURATION
// - RISCV_MUL_EARLY_OUT_EN defined: in CALC, if remaining mplr == 0, exit to FIX
//   after current step (min 1 CALC cycle); latency becomes data-dependent.
// - Undefined: always exactly NSTEP CALC cycles (fixed latency).
// STRUCTURE
// - riscv_core_mul_pkg: mul_op_e (MUL/MULH/MULHSU/MULHU), mul_state_e
//   (IDLE/CALC/FIX/DONE), opcode constants.
// - Sub-module riscv_core_mul_step: combinational one-iteration partial product + add
//   (inputs acc, mcnd, mplr digit, step; output next acc).
// TESTING
// - MUL 7*-3 (XLEN=64,R=4) -> 0xFFFF_FFFF_FFFF_FFEB; valid after NSTEP+1=17 edges.
// - MULH 0x8000..0 * 0x8000..0 -> 0x4000_0000_0000_0000; MULHU all-ones^2 -> 0xFFFF..FFFE.
// - MULHSU -1 * 0xFFFF..FFFF -> 0xFFFF_FFFF_FFFF_FFFF; MULW 0x7FFFFFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE.
// - Flush at CALC step 5 -> IDLE next edge, no out_valid; next op result correct.
// - Hold i_mul_out_ready=0 for 10 cycles in DONE -> result stable, in_ready stays 0.
// - EARLY_OUT_EN: MUL x*1 -> CALC 1 cycle, result x; random 10k vs reference model, R in {1,2,4,8}.

Source files
------------

// File: rtl/riscv_core_mul_pkg.sv
// Shared types for the iterative RV64M multiplier: operation codes and FSM states.
package riscv_core_mul_pkg;

    localparam logic [1:0] MUL_CTL_MUL    = 2'b00;
    localparam logic [1:0] MUL_CTL_MULH   = 2'b01;
    localparam logic [1:0] MUL_CTL_MULHSU = 2'b10;
    localparam logic [1:0] MUL_CTL_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        OP_MUL    = MUL_CTL_MUL,
        OP_MULH   = MUL_CTL_MULH,
        OP_MULHSU = MUL_CTL_MULHSU,
        OP_MULHU  = MUL_CTL_MULHU
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

endpackage

// File: rtl/riscv_core_mul_step.sv
// One multiplier iteration: adds the shifted partial product of one multiplier digit.
module riscv_core_mul_step #(
    parameter int XLEN       = 64,
    parameter int RADIX_BITS = 4,
    parameter int STEP_W     = 4
) (
    input  logic [2*XLEN-1:0]     acc_i,
    input  logic [XLEN-1:0]       mcnd_i,
    input  logic [RADIX_BITS-1:0] digit_i,
    input  logic [STEP_W-1:0]     step_i,
    output logic [2*XLEN-1:0]     acc_o
);

    logic [2*XLEN-1:0] pp_d;
    logic [31:0]       shamt_d;

    // Partial product of the current digit, aligned to its bit position.
    always_comb begin
        shamt_d = 32'(step_i) * $unsigned(32'(RADIX_BITS));
        pp_d    = ({{XLEN{1'b0}}, mcnd_i} * {{(2*XLEN-RADIX_BITS){1'b0}}, digit_i}) << shamt_d;
        acc_o   = acc_i + pp_d;
    end

endmodule

// File: rtl/riscv_core_mul_iter.sv
// Iterative RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW), RADIX_BITS bits per cycle.
// Optional RISCV_MUL_EARLY_OUT_EN: leave CALC once the remaining multiplier is zero.
module riscv_core_mul_iter
    import riscv_core_mul_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int RADIX_BITS = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mul_in_valid,
    output logic            o_mul_in_ready,
    input  logic [XLEN-1:0] i_mul_srcA,
    input  logic [XLEN-1:0] i_mul_srcB,
    input  logic [1:0]      i_mul_control,
    input  logic            i_mul_isword,
    input  logic            i_mul_flush,
    output logic            o_mul_out_valid,
    input  logic            i_mul_out_ready,
    output logic [XLEN-1:0] o_mul_result,
    output logic            o_mul_busy
);

    localparam int NSTEP_FULL = XLEN / RADIX_BITS;
    localparam int NSTEP_WORD = 32 / RADIX_BITS;
    localparam int STEP_W     = $clog2(NSTEP_FULL);
    localparam logic [STEP_W-1:0] LAST_FULL = STEP_W'(NSTEP_FULL - 1);
    localparam logic [STEP_W-1:0] LAST_WORD = STEP_W'(NSTEP_WORD - 1);
    localparam logic [XLEN-1:0]   WORD_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);

    mul_state_e        state_q;
    mul_op_e           op_q;
    logic              word_q;
    logic              neg_q;
    logic [XLEN-1:0]   mcnd_q;
    logic [XLEN-1:0]   mplr_q;
    logic [2*XLEN-1:0] acc_q;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] last_step_q;
    logic [XLEN-1:0]   result_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    mul_op_e           op_in_d;
    logic              a_neg_d;
    logic              b_neg_d;
    logic [XLEN-1:0]   opa_d;
    logic [XLEN-1:0]   opb_d;
    logic [XLEN-1:0]   mag_a_d;
    logic [XLEN-1:0]   mag_b_d;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   mplr_d;
    logic              calc_done_d;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   result_d;

    riscv_core_mul_step #(
        .XLEN       (XLEN),
        .RADIX_BITS (RADIX_BITS),
        .STEP_W     (STEP_W)
    ) u_step (
        .acc_i   (acc_q),
        .mcnd_i  (mcnd_q),
        .digit_i (mplr_q[RADIX_BITS-1:0]),
        .step_i  (step_q),
        .acc_o   (acc_d)
    );

    // Operand magnitudes and result sign; MULW multiplies the low words unsigned.
    always_comb begin
        op_in_d = mul_op_e'(i_mul_control);
        a_neg_d = 1'b0;
        b_neg_d = 1'b0;
        if (i_mul_isword) begin
            opa_d = i_mul_srcA & WORD_MASK;
            opb_d = i_mul_srcB & WORD_MASK;
        end else begin
            opa_d   = i_mul_srcA;
            opb_d   = i_mul_srcB;
            a_neg_d = (op_in_d != OP_MULHU) && i_mul_srcA[XLEN-1];
            b_neg_d = ((op_in_d == OP_MUL) || (op_in_d == OP_MULH)) && i_mul_srcB[XLEN-1];
        end
        mag_a_d = a_neg_d ? ({XLEN{1'b0}} - opa_d) : opa_d;
        mag_b_d = b_neg_d ? ({XLEN{1'b0}} - opb_d) : opb_d;
    end

    // Iteration exit test and final sign fix / half select.
    always_comb begin
        mplr_d = mplr_q >> RADIX_BITS;
`ifdef RISCV_MUL_EARLY_OUT_EN
        calc_done_d = (step_q == last_step_q) || (mplr_d == {XLEN{1'b0}});
`else
        calc_done_d = (step_q == last_step_q);
`endif
        prod_d = neg_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
        if (word_q) begin
            result_d = XLEN'($signed(prod_d[31:0]));
        end else begin
            case (op_q)
                OP_MUL:  result_d = prod_d[XLEN-1:0];
                default: result_d = prod_d[2*XLEN-1:XLEN];
            endcase
        end
    end

    // Control FSM with registered handshake/status outputs; flush beats every other event.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            word_q      <= 1'b0;
            neg_q       <= 1'b0;
            mcnd_q      <= {XLEN{1'b0}};
            mplr_q      <= {XLEN{1'b0}};
            acc_q       <= {(2*XLEN){1'b0}};
            step_q      <= {STEP_W{1'b0}};
            last_step_q <= {STEP_W{1'b0}};
            result_q    <= {XLEN{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (i_mul_flush) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_mul_in_valid) begin
                        state_q     <= ST_CALC;
                        op_q        <= op_in_d;
                        word_q      <= i_mul_isword;
                        neg_q       <= a_neg_d ^ b_neg_d;
                        mcnd_q      <= mag_a_d;
                        mplr_q      <= mag_b_d;
                        acc_q       <= {(2*XLEN){1'b0}};
                        step_q      <= {STEP_W{1'b0}};
                        last_step_q <= i_mul_isword ? LAST_WORD : LAST_FULL;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_d;
                    step_q <= step_q + STEP_W'(1'b1);
                    if (calc_done_d) begin
                        state_q <= ST_FIX;
                    end else begin
                        state_q <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    result_q    <= result_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_mul_out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q     <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign o_mul_in_ready  = in_ready_q;
    assign o_mul_out_valid = out_valid_q;
    assign o_mul_result    = result_q;
    assign o_mul_busy      = busy_q;

endmodule
